seq_div: RTL
============

SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 16, operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: unsigned numerator, captured with start.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: unsigned denominator, captured with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in RUN or DONE.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse; results valid.
REQ-009 The block SHALL have port quotient, output, WIDTH bits: result quotient.
REQ-010 The block SHALL have port remainder, output, WIDTH bits: result remainder.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: high with done when the captured divisor was 0.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and DONE, all transitions on the rising clk edge.
REQ-013 In IDLE with start=1 at edge T0, the block SHALL capture dividend and divisor, set busy=1 and take one of two paths:
- divisor non-zero: enter RUN;
- divisor zero: enter DONE.
REQ-014 In RUN, the block SHALL perform one restoring shift-subtract iteration per clock, MSB of dividend first, using a (WIDTH+1)-bit partial remainder:
- shift the remainder left, bringing in the next dividend bit;
- if remainder >= divisor, subtract divisor and set the quotient bit to 1; otherwise set it to 0.
REQ-015 An iteration counter SHALL run from 0 to WIDTH-1; after the iteration with count WIDTH-1 (edge T_WIDTH), the FSM SHALL enter DONE.
REQ-016 For a non-zero divisor, done SHALL be 1 during the cycle following edge T_WIDTH (T16 for WIDTH=16); latency is WIDTH cycles from the start edge.
REQ-017 For a zero divisor, done SHALL be 1 during the cycle following edge T1, with:
- quotient = all ones;
- remainder = dividend;
- div_by_zero = 1.
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE with done=0 and busy=0.
REQ-019 quotient, remainder and div_by_zero SHALL hold their values after DONE until the next accepted start.
REQ-020 On an accepted start, the block SHALL clear div_by_zero.
REQ-021 quotient and remainder SHALL NOT be guaranteed valid while busy=1 and done=0.
REQ-022 start SHALL be ignored in RUN and DONE; no queuing, and captured operands SHALL be unaffected.
REQ-023 Input operand changes after the start edge SHALL have no effect on the running operation.
REQ-024 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every non-zero divisor, including:
- dividend < divisor: quotient 0, remainder = dividend;
- dividend = 0: quotient 0, remainder 0;
- divisor = 1: quotient = dividend, remainder 0.

Reset
REQ-025 When rst_n=0, the block SHALL, immediately and independent of clk:
- force the state to IDLE;
- set busy, done, div_by_zero, quotient, remainder and the iteration counter to 0.
REQ-026 Assertion of rst_n mid-RUN SHALL abort the operation with no done pulse.
REQ-027 The first start SHALL be sampled at the first rising edge after rst_n deasserts.

Verification
REQ-028 Bench SHALL cover: start with 100/7 -> done one cycle after edge T16, quotient=14, remainder=2, div_by_zero=0, busy low the cycle after.
REQ-029 Bench SHALL cover: start with 0xFFFF/0x0001 -> quotient=0xFFFF, remainder=0x0000; then 3/10 -> quotient=0, remainder=3.
REQ-030 Bench SHALL cover: start with 5/0 -> done one cycle after edge T1, quotient=0xFFFF, remainder=5, div_by_zero=1.
REQ-031 Bench SHALL cover: start with 1000/9, then start pulsed with 8/2 at T5 -> exactly one done, after T16, quotient=111, remainder=1.
REQ-032 Bench SHALL cover: start with 50000/123, rst_n low at T8 -> all outputs 0 immediately, no done; a new start with 50000/123 after reset -> quotient=406, remainder=62.
REQ-033 Bench SHALL cover: a random check of 10000 operand pairs, including 0 and 0xFFFF edges, against a reference model, checking the identity and the latency of REQ-016.

Source files
------------

// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// A zero divisor short-circuits to a saturated result flagged by div_by_zero.
module seq_div #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // quotient doubles as the dividend shift register while running
    always_comb begin
        shifted = {rem_acc, quotient[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvsr});
        diff    = shifted[WIDTH-1:0] - dvsr;
    end

    assign remainder = rem_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            rem_acc     <= '0;
            dvsr        <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        dvsr        <= divisor;
                        cnt         <= '0;
                        if (divisor == '0) begin
                            quotient <= '1;
                            rem_acc  <= dividend;
                            state    <= DONE;
                        end else begin
                            quotient <= dividend;
                            rem_acc  <= '0;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_acc  <= fits ? diff : shifted[WIDTH-1:0];
                    quotient <= {quotient[WIDTH-2:0], fits};
                    cnt      <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // zero-divisor path arrives with done low and raises it one cycle later
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
